// File: rtl/apb2axi_pkg.sv
// APB2AXI bridge shared types and defaults.
// Imported by the APB slave controller, its interface and the wait timer.
package apb2axi_pkg;

  localparam int APB_ADDR_W           = 32;
  localparam int APB_DATA_W           = 32;
  localparam int APB2AXI_TIMEOUT_DFLT = 256;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } apb_ctrl_state_e;

endpackage

// File: rtl/apb2axi_apb_slave_ctrl_if.sv
// APB port plus request/response channels of the APB slave controller.
// slave: controller side; master: APB master and AXI engine side.
interface apb2axi_apb_slave_ctrl_if
  import apb2axi_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
) ();

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/apb2axi_wait_timer.sv
// Wait-state counter for the APB slave controller.
// o_expired flags the last allowed cycle (count == TIMEOUT_CYCLES-1).
module apb2axi_wait_timer
  import apb2axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB2AXI_TIMEOUT_DFLT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == LAST);

endmodule

// File: rtl/apb2axi_apb_slave_ctrl.sv
// APB slave controller: one APB transfer -> one request/response pair.
// Define APB2AXI_TIMEOUT_EN to bound wait states and drain late responses.
module apb2axi_apb_slave_ctrl
  import apb2axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB2AXI_TIMEOUT_DFLT
) (
  input logic                     PCLK,
  input logic                     PRESETn,
  apb2axi_apb_slave_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  apb_ctrl_state_e r_state;
  apb_ctrl_state_e w_nstate;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_setup;
  logic w_req_hs;
  logic w_rsp_hs;
  logic w_expired;
  logic w_drain;
  logic w_to_err;

  assign w_setup  = bus.PSEL && !bus.PENABLE;
  assign w_req_hs = (r_state == REQ) && bus.req_ready;

`ifdef APB2AXI_TIMEOUT_EN
  logic r_drain;

  apb2axi_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .i_clr    ((r_state == IDLE) && w_setup),
    .i_run    ((r_state == REQ) || (r_state == WAIT_RSP)),
    .o_expired(w_expired)
  );

  // A response still owed to a timed-out transfer is swallowed first
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_drain <= 1'b0;
    end else if (w_to_err && (r_state == WAIT_RSP)) begin
      r_drain <= 1'b1;
    end else if (r_drain && bus.rsp_valid) begin
      r_drain <= 1'b0;
    end
  end

  assign w_drain = r_drain;
`else
  assign w_expired = 1'b0;
  assign w_drain   = 1'b0;
`endif

  assign w_rsp_hs = (r_state == WAIT_RSP) && bus.rsp_valid && !w_drain;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_to_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_setup) w_nstate = REQ;
      end
      REQ: begin
        if (w_req_hs) begin
          w_nstate = WAIT_RSP;
        end else if (w_expired) begin
          w_nstate = DONE;
          w_to_err = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (w_rsp_hs) begin
          w_nstate = DONE;
        end else if (w_expired) begin
          w_nstate = DONE;
          w_to_err = 1'b1;
        end
      end
      DONE: begin
        w_nstate = IDLE;
      end
      default: begin
        w_nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_setup) begin
        r_addr  <= bus.PADDR;
        r_wdata <= bus.PWDATA;
        r_write <= bus.PWRITE;
      end
      if (w_rsp_hs) begin
        r_err   <= bus.rsp_err;
        r_rdata <= r_write ? '0 : bus.rsp_rdata;
      end else if (w_to_err) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign bus.PREADY    = (r_state == DONE);
  assign bus.PRDATA    = (r_state == DONE) ? r_rdata : '0;
  assign bus.PSLVERR   = (r_state == DONE) && r_err;
  assign bus.req_valid = (r_state == REQ);
  assign bus.req_write = r_write;
  assign bus.req_addr  = r_addr;
  assign bus.req_wdata = r_wdata;
  assign bus.rsp_ready = (r_state == WAIT_RSP) || w_drain;

endmodule

// File: tb/tb_apb2axi_apb_slave_ctrl.sv
// Scoreboard bench for apb2axi_apb_slave_ctrl: directed plus random APB
// transfers, with a delay-programmable downstream responder.
module tb_apb2axi_apb_slave_ctrl;
  import apb2axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  always #5 PCLK = ~PCLK;

  apb2axi_apb_slave_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb2axi_apb_slave_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
    int            waits;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int n_vec = 0;
  int n_bad = 0;

  int            dn_req_dly = 0;
  int            dn_rsp_dly = 0;
  logic [DW-1:0] dn_rdata   = '0;
  logic          dn_err     = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Downstream: hold req_ready low dn_req_dly cycles, then answer
  // dn_rsp_dly cycles after the request handshake.
  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    forever begin
      @(negedge PCLK);
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      if (!PRESETn) ph = 0;
      if (ph == 0 && PRESETn && bus.req_valid) begin
        ph = 1;
        cnt = dn_req_dly;
      end
      if (ph == 1) begin
        if (cnt == 0) begin
          bus.req_ready = 1'b1;
          ph = 2;
          cnt = dn_rsp_dly + 1;
        end else begin
          cnt--;
        end
      end else if (ph == 2) begin
        cnt--;
        if (cnt == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = dn_rdata;
          bus.rsp_err   = dn_err;
          ph = 0;
        end
      end
    end
  end

  // Monitor: request handshakes and APB completions against the queues
  initial begin
    int   w;
    logic hs_prev;
    req_t r;
    cmp_t e;
    w = 0;
    hs_prev = 1'b0;
    forever begin
      @(negedge PCLK);
      #1;
      if (!PRESETn) begin
        w = 0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) chk("req_gap", 64'(bus.req_valid), 64'(0));
        hs_prev = bus.req_valid && bus.req_ready;
        if (hs_prev) begin
          if (req_q.size() == 0) begin
            chk("req_unexpected", 64'(1), 64'(0));
          end else begin
            r = req_q.pop_front();
            chk("req_write", 64'(bus.req_write), 64'(r.w));
            chk("req_addr", 64'(bus.req_addr), 64'(r.a));
            chk("req_wdata", 64'(bus.req_wdata), 64'(r.d));
          end
        end
        if (bus.PREADY) begin
          if (cmp_q.size() == 0) begin
            chk("pready_unexpected", 64'(1), 64'(0));
          end else begin
            e = cmp_q.pop_front();
            chk("prdata", 64'(bus.PRDATA), 64'(e.rd));
            chk("pslverr", 64'(bus.PSLVERR), 64'(e.err));
            chk("wait_states", 64'(w), 64'(e.waits));
          end
          w = 0;
        end else if (bus.PSEL && bus.PENABLE) begin
          chk("wait_outputs", {31'd0, bus.PSLVERR, bus.PRDATA}, 64'(0));
          w++;
        end
      end
    end
  end

  // Reference: 2 + stall cycles; a stall past the timeout limit ends in an error
  task automatic xfer(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int rd, input int sd,
                      input logic [DW-1:0] rdat, input logic er);
    req_t r;
    cmp_t e;
    int   n;
    logic push_req;
    r.w = w;
    r.a = a;
    r.d = d;
    e.waits = 2 + rd + sd;
    e.err = er;
    e.rd = w ? '0 : rdat;
    push_req = 1'b1;
`ifdef APB2AXI_TIMEOUT_EN
    if (e.waits > TO) begin
      e.waits = TO;
      e.err = 1'b1;
      e.rd = '0;
    end
    if (rd >= TO) push_req = 1'b0;
`endif
    if (push_req) req_q.push_back(r);
    cmp_q.push_back(e);
    dn_req_dly = rd;
    dn_rsp_dly = sd;
    dn_rdata = rdat;
    dn_err = er;
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = w;
    bus.PADDR = a;
    bus.PWDATA = d;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    n = 0;
    while (!bus.PREADY && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.PREADY) chk("pready_timeout", 64'(0), 64'(1));
    @(negedge PCLK);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  initial begin
    req_t r;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_pready", 64'(bus.PREADY), 64'(0));
    chk("rst_pslverr", 64'(bus.PSLVERR), 64'(0));
    chk("rst_prdata", 64'(bus.PRDATA), 64'(0));
    chk("rst_req_valid", 64'(bus.req_valid), 64'(0));
    chk("rst_rsp_ready", 64'(bus.rsp_ready), 64'(0));
    chk("rst_req_fields",
        {31'd0, bus.req_write, bus.req_addr} | 64'(bus.req_wdata), 64'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
    xfer(1'b0, 32'h20, 32'h0, 4, 3, 32'h12345678, 1'b0);
    xfer(1'b0, 32'h24, 32'h0, 0, 1, 32'hAAAA5555, 1'b1);
    xfer(1'b1, 32'h28, 32'h1, 0, 0, 32'h0, 1'b0);
    xfer(1'b1, 32'h30, 32'h5, 1, 2, 32'hFFFF0000, 1'b0);
    xfer(1'b1, 32'h34, 32'h77, 0, 0, 32'h0, 1'b0);
    xfer(1'b1, 32'h38, 32'h88, 0, 0, 32'h0, 1'b0);

    // Reset in the middle of WAIT_RSP
    r.w = 1'b0;
    r.a = 32'h40;
    r.d = 32'h9;
    req_q.push_back(r);
    dn_req_dly = 0;
    dn_rsp_dly = 30;
    bus.PSEL = 1'b1;
    bus.PWRITE = 1'b0;
    bus.PADDR = 32'h40;
    bus.PWDATA = 32'h9;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_rsp_ready", 64'(bus.rsp_ready), 64'(1));
    #3 PRESETn = 1'b0;
    #1;
    chk("async_rsp_ready", 64'(bus.rsp_ready), 64'(0));
    chk("async_pready", 64'(bus.PREADY), 64'(0));
    chk("async_req_addr", 64'(bus.req_addr), 64'(0));
    @(negedge PCLK);
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    xfer(1'b0, 32'h44, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0);

`ifdef APB2AXI_TIMEOUT_EN
    xfer(1'b0, 32'h50, 32'h0, 0, 20, 32'h11111111, 1'b0);
    chk("drain_rsp_ready", 64'(bus.rsp_ready), 64'(1));
    repeat (20) @(negedge PCLK);
    chk("drain_cleared", 64'(bus.rsp_ready), 64'(0));
    xfer(1'b0, 32'h54, 32'h0, 1, 0, 32'h87654321, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge PCLK);
    chk("queues_drained", 64'(cmp_q.size() + req_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
